seven_seg_scan_ctrl: RTL



---
 rtl/seven_seg_scan_ctrl.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Cycles through digits 0..3 with a blanking gap at the start of each slot,
// decodes BCD to glyphs, and swaps in new values only at frame boundaries.
module seven_seg_scan_ctrl #(
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        load,
  input  logic [15:0] bcd_in,
  input  logic [3:0]  dp_sel,
  input  logic        lz_blank,
  output logic        upd_ack,
  output logic        frame_tick,
  output logic [3:0]  an,
  output logic [7:0]  seg
);

  localparam int            CW        = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK_CYC);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic [15:0]   bcd_act_q, bcd_act_d, bcd_pnd_q, bcd_pnd_d;
  logic [3:0]    dp_act_q, dp_act_d, dp_pnd_q, dp_pnd_d;
  logic          lz_act_q, lz_act_d, lz_pnd_q, lz_pnd_d;
  logic          pnd_flag_q, pnd_flag_d;
  logic          upd_ack_q, upd_ack_d;
  logic          frame_tick_q, frame_tick_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;

  logic          wrap, last_slot, xfer;
  logic [3:0]    digit;
  logic [3:0]    lz_mask;

  // Active-low g..a pattern; non-BCD codes show a dash.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    case (code)
      4'd0:    glyph = 7'b1000000;
      4'd1:    glyph = 7'b1111001;
      4'd2:    glyph = 7'b0100100;
      4'd3:    glyph = 7'b0110000;
      4'd4:    glyph = 7'b0011001;
      4'd5:    glyph = 7'b0010010;
      4'd6:    glyph = 7'b0000010;
      4'd7:    glyph = 7'b1011000;
      4'd8:    glyph = 7'b0000000;
      4'd9:    glyph = 7'b0010000;
      default: glyph = 7'b0111111;
    endcase
  endfunction

  // Scan timing: slot counter, digit index and frame boundary detection.
  always_comb begin
    wrap      = en && (cnt_q == CNT_LAST);
    last_slot = wrap && (idx_q == 2'd3);
    cnt_d     = '0;
    idx_d     = '0;
    if (en) begin
      cnt_d = wrap ? '0 : cnt_q + CW'(1);
      idx_d = wrap ? idx_q + 2'd1 : idx_q;
    end
    frame_tick_d = last_slot;
  end

  // Pending/active double buffer; while disabled there is no frame to wait for.
  always_comb begin
    xfer       = pnd_flag_q && (en ? last_slot : 1'b1);
    bcd_pnd_d  = load ? bcd_in   : bcd_pnd_q;
    dp_pnd_d   = load ? dp_sel   : dp_pnd_q;
    lz_pnd_d   = load ? lz_blank : lz_pnd_q;
    pnd_flag_d = load | (pnd_flag_q & ~xfer);
    bcd_act_d  = xfer ? bcd_pnd_q : bcd_act_q;
    dp_act_d   = xfer ? dp_pnd_q  : dp_act_q;
    lz_act_d   = xfer ? lz_pnd_q  : lz_act_q;
    upd_ack_d  = xfer;
  end

  // Leading-zero mask: a digit blanks when it and everything to its left is zero.
  always_comb begin
    lz_mask[3] = (bcd_act_q[15:12] == 4'd0);
    lz_mask[2] = lz_mask[3] && (bcd_act_q[11:8] == 4'd0);
    lz_mask[1] = lz_mask[2] && (bcd_act_q[7:4] == 4'd0);
    lz_mask[0] = 1'b0;
  end

  // Anode/segment drive for the current slot, registered one cycle later.
  always_comb begin
    digit = bcd_act_q[{idx_q, 2'b00} +: 4];
    an_d  = 4'hF;
    seg_d = 8'hFF;
    if (en && (cnt_q >= CNT_BLANK)) begin
      an_d       = ~(4'b0001 << idx_q);
      seg_d[7]   = ~dp_act_q[idx_q];
      seg_d[6:0] = (lz_act_q && lz_mask[idx_q]) ? 7'h7F : glyph(digit);
    end
  end

  // State registers; reset drops any pending update without acknowledging it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      bcd_act_q    <= '0;
      dp_act_q     <= '0;
      lz_act_q     <= 1'b0;
      bcd_pnd_q    <= '0;
      dp_pnd_q     <= '0;
      lz_pnd_q     <= 1'b0;
      pnd_flag_q   <= 1'b0;
      upd_ack_q    <= 1'b0;
      frame_tick_q <= 1'b0;
      an_q         <= 4'hF;
      seg_q        <= 8'hFF;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      bcd_act_q    <= bcd_act_d;
      dp_act_q     <= dp_act_d;
      lz_act_q     <= lz_act_d;
      bcd_pnd_q    <= bcd_pnd_d;
      dp_pnd_q     <= dp_pnd_d;
      lz_pnd_q     <= lz_pnd_d;
      pnd_flag_q   <= pnd_flag_d;
      upd_ack_q    <= upd_ack_d;
      frame_tick_q <= frame_tick_d;
      an_q         <= an_d;
      seg_q        <= seg_d;
    end
  end

  assign upd_ack    = upd_ack_q;
  assign frame_tick = frame_tick_q;
  assign an         = an_q;
  assign seg        = seg_q;

endmodule
